// File: rtl/instr_decoder.sv
// Single registered decode stage: instruction word in, ALU/register-file control bundle out.
// Optional illegal-instruction counter output enabled by DEC_ILLEGAL_CNT_EN.
`timescale 1ns/1ps

module instr_decoder #(
  parameter int unsigned NUM_FUNCT  = 9,
  parameter int unsigned MAX_IMM_OP = 6,
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        resume,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_funct,
  output logic [15:0] alu_imm,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  rd_addr,
  output logic        wr_en,
  output logic        illegal,
  output logic        err,
`ifdef DEC_ILLEGAL_CNT_EN
  output logic [15:0] illegal_cnt,
`endif
  output logic        halted
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e state;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic        is_r;
  logic        is_i;
  logic        is_halt;
  logic        is_ill;
  logic        accept;

  logic [5:0]  dec_opcode;
  logic [5:0]  dec_funct;
  logic [15:0] dec_imm;
  logic [4:0]  dec_rd;
  logic        dec_wr;

  assign op = in_instr[31:26];
  assign fn = in_instr[5:0];

  // Instruction classification
  always_comb begin
    is_r    = (op == 6'd0) && ({26'd0, fn} < NUM_FUNCT);
    is_i    = (op != 6'd0) && ({26'd0, op} <= MAX_IMM_OP);
    is_halt = (op == HALT_OP) && !is_r && !is_i;
    is_ill  = !(is_r || is_i || is_halt);
  end

  // Field extraction; illegal words keep raw register addresses but zero ALU fields
  always_comb begin
    dec_opcode = 6'd0;
    dec_funct  = 6'd0;
    dec_imm    = 16'd0;
    dec_rd     = in_instr[15:11];
    dec_wr     = 1'b0;
    if (is_r) begin
      dec_funct = fn;
      dec_wr    = 1'b1;
    end else if (is_i) begin
      dec_opcode = op;
      dec_imm    = in_instr[15:0];
      dec_rd     = in_instr[20:16];
      dec_wr     = 1'b1;
    end
    // r0 is hardwired, never written
    if (dec_rd == 5'd0) begin
      dec_wr = 1'b0;
    end
  end

  assign in_ready = !rst && (state == StRun) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StRun;
      halted     <= 1'b0;
      out_valid  <= 1'b0;
      alu_opcode <= 6'd0;
      alu_funct  <= 6'd0;
      alu_imm    <= 16'd0;
      rs_addr    <= 5'd0;
      rt_addr    <= 5'd0;
      rd_addr    <= 5'd0;
      wr_en      <= 1'b0;
      illegal    <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (accept && !is_halt) begin
        out_valid  <= 1'b1;
        alu_opcode <= dec_opcode;
        alu_funct  <= dec_funct;
        alu_imm    <= dec_imm;
        rs_addr    <= in_instr[25:21];
        rt_addr    <= in_instr[20:16];
        rd_addr    <= dec_rd;
        wr_en      <= dec_wr;
        illegal    <= is_ill;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        StRun: begin
          if (accept && is_halt) begin
            state  <= StHalted;
            halted <= 1'b1;
          end
        end
        StHalted: begin
          if (resume) begin
            state  <= StRun;
            halted <= 1'b0;
          end
        end
      endcase

      if (accept && is_ill) begin
        err <= 1'b1;
      end
    end
  end

`ifdef DEC_ILLEGAL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= 16'd0;
    end else if (accept && is_ill && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// Randomised scoreboard bench for instr_decoder: driver pushes expected bundles, monitor pops.
`timescale 1ns/1ps

module tb_instr_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        resume;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  alu_opcode;
  logic [5:0]  alu_funct;
  logic [15:0] alu_imm;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic        wr_en;
  logic        illegal;
  logic        err;
  logic        halted;
`ifdef DEC_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt;
`endif

  instr_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .resume     (resume),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_opcode (alu_opcode),
    .alu_funct  (alu_funct),
    .alu_imm    (alu_imm),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .wr_en      (wr_en),
    .illegal    (illegal),
    .err        (err),
`ifdef DEC_ILLEGAL_CNT_EN
    .illegal_cnt(illegal_cnt),
`endif
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Expected bundle: {opcode, funct, imm, rs, rt, rd, wr_en, illegal}
  logic [44:0] sb_q[$];
  logic        m_halted = 1'b0;
  logic        m_err    = 1'b0;
  int          m_cnt    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // 0 = R-type, 1 = I-type, 2 = HALT, 3 = illegal
  function automatic int cls_of(input logic [31:0] i);
    int op;
    int fn;
    op = int'(i[31:26]);
    fn = int'(i[5:0]);
    if (op == 0 && fn < 9) return 0;
    if (op >= 1 && op <= 6) return 1;
    if (op == 63) return 2;
    return 3;
  endfunction

  function automatic logic [44:0] exp_of(input logic [31:0] i);
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    rs = i[25:21];
    rt = i[20:16];
    case (cls_of(i))
      0: begin
        rd = i[15:11];
        return {6'd0, i[5:0], 16'd0, rs, rt, rd, rd != 5'd0, 1'b0};
      end
      1: begin
        rd = i[20:16];
        return {i[31:26], 6'd0, i[15:0], rs, rt, rd, rd != 5'd0, 1'b0};
      end
      default: begin
        rd = i[15:11];
        return {6'd0, 6'd0, 16'd0, rs, rt, rd, 1'b0, 1'b1};
      end
    endcase
  endfunction

  // One cycle of stimulus; returns 1 ns after the falling edge, before the next rising edge
  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic res);
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    resume    = res;
    #1;
    check("halted", 64'(halted), 64'(m_halted));
    check("err", 64'(err), 64'(m_err));
`ifdef DEC_ILLEGAL_CNT_EN
    check("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
`endif
    if (m_halted) check("in_ready_halted", 64'(in_ready), 64'(0));
    if (in_valid && in_ready) begin
      case (cls_of(in_instr))
        2: m_halted = 1'b1;
        3: begin
          sb_q.push_back(exp_of(in_instr));
          m_err = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
        default: sb_q.push_back(exp_of(in_instr));
      endcase
    end else if (m_halted && res) begin
      m_halted = 1'b0;
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int c;
    w = $urandom;
    c = $urandom_range(0, 9);
    if (c <= 3) begin
      w[31:26] = 6'd0;
      w[5:0]   = 6'($urandom_range(0, 11));
    end else if (c <= 6) begin
      w[31:26] = 6'($urandom_range(1, 6));
    end else if (c <= 8) begin
      w[31:26] = 6'($urandom_range(7, 62));
    end else begin
      w[31:26] = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'd0;
    end
    return w;
  endfunction

  // Monitor: compares each consumed bundle and checks stability under backpressure
  logic [44:0] prev;
  logic        have_prev = 1'b0;
  initial begin
    logic [44:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (rst || !out_valid) begin
        have_prev = 1'b0;
      end else begin
        act = {alu_opcode, alu_funct, alu_imm, rs_addr, rt_addr, rd_addr, wr_en, illegal};
        if (have_prev) check("hold", 64'(act), 64'(prev));
        if (out_ready) begin
          if (sb_q.size() == 0) check("unexpected_bundle", 64'(out_valid), 64'(0));
          else check("bundle", 64'(act), 64'(sb_q.pop_front()));
          have_prev = 1'b0;
        end else begin
          prev      = act;
          have_prev = 1'b1;
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    out_ready = 1'b0;
    resume    = 1'b0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_fields", 64'({alu_opcode, alu_funct, alu_imm, rd_addr, wr_en, illegal}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // R-type and I-type reference words
    drive(1'b1, 32'h00221800, 1'b1, 1'b0);
    drive(1'b1, 32'h048500FF, 1'b1, 1'b0);
    check("r_out_valid", 64'(out_valid), 64'(1));
    check("r_rd", 64'({rs_addr, rt_addr, rd_addr, wr_en}), 64'({5'd1, 5'd2, 5'd3, 1'b1}));
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    check("i_imm", 64'({alu_opcode, alu_imm, rd_addr, alu_funct}),
          64'({6'd1, 16'h00FF, 5'd5, 6'd0}));

    // Backpressure: first bundle held four cycles, then three bundles drain in order
    drive(1'b1, 32'h0C4A1234, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h00E63802, 1'b0, 1'b0);
      check("bp_in_ready", 64'(in_ready), 64'(0));
    end
    drive(1'b1, 32'h00E63802, 1'b1, 1'b0);
    drive(1'b1, 32'h1D2A0F0F, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);

    // Illegal: funct beyond the legal range
    drive(1'b1, 32'h00000009, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    check("ill_bundle", 64'({out_valid, illegal, wr_en}), 64'({1'b1, 1'b1, 1'b0}));
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    check("err_sticky", 64'(err), 64'(1));

    // HALT, five stalled cycles, then resume
    drive(1'b1, 32'hFC000000, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h00221800, 1'b1, 1'b0);
      check("halt_stall", 64'({halted, in_ready, out_valid}), 64'({1'b1, 1'b0, 1'b0}));
    end
    drive(1'b0, 32'd0, 1'b1, 1'b1);
    drive(1'b1, 32'h00221800, 1'b1, 1'b0);
    check("resume_in_ready", 64'(in_ready), 64'(1));
    drive(1'b0, 32'd0, 1'b1, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 9) < 7, gen_instr(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 99) < 15);
    end

    // Leave HALTED and drain before the async reset scenario
    drive(1'b0, 32'd0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b0, 32'd0, 1'b1, 1'b0);
    drive(1'b1, 32'h00000009, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("pre_rst_valid", 64'({out_valid, err}), 64'({1'b1, 1'b1}));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 64'({out_valid, err, halted, in_ready}), 64'(0));
    sb_q.delete();
    m_err    = 1'b0;
    m_halted = 1'b0;
    m_cnt    = 0;
    @(negedge clk);
    rst = 1'b0;

    drive(1'b1, 32'h00221800, 1'b1, 1'b0);
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) drive(1'b0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
Name: instr_decoder

Overview:
Front end of the execute datapath: accepts 32-bit instruction words from fetch over a valid/ready handshake and decodes them into the ALU control fields (opcode, funct, imm) plus register-file addresses and a write enable. It is a single registered decode stage with backpressure, illegal-instruction detection and a HALT state. It sits between instruction fetch and register read / ALU.

Parameters:
NUM_FUNCT, 9, number of legal R-type funct codes (0 .. NUM_FUNCT-1)
MAX_IMM_OP, 6, highest legal immediate-class opcode (1 .. MAX_IMM_OP)
HALT_OP, 6'b111111, opcode of the HALT instruction

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  fetch presents instr
in_instr  in  32  instruction word
in_ready  out  1  decoder accepts instr this cycle
resume  in  1  single-cycle pulse, leaves HALTED
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
alu_opcode  out  6  instr[31:26]
alu_funct  out  6  instr[5:0] for R-type, 0 otherwise
alu_imm  out  16  instr[15:0] for I-type, 0 otherwise
rs_addr  out  5  instr[25:21]
rt_addr  out  5  instr[20:16]
rd_addr  out  5  destination: instr[15:11] for R-type, instr[20:16] for I-type
wr_en  out  1  register write enable for the bundle
illegal  out  1  bundle is an illegal instruction (NOP)
err  out  1  sticky: an illegal instruction was seen
halted  out  1  FSM in HALTED

Behaviour:
- Reset: out_valid=0, all field outputs 0, wr_en=0, illegal=0, err=0, state=RUN. halted=0. in_ready low while rst is asserted.
- Handshake: in_ready = (state==RUN) && (!out_valid || out_ready). Transfer when in_valid && in_ready. Output holds stable while out_valid && !out_ready.
- Latency: instr accepted on edge N → bundle on outputs with out_valid=1 after edge N; 1 instr/cycle throughput under continuous out_ready.
- out_valid clears on an out_ready edge with no new transfer.
- Classes:
  - R-type: opcode 0, funct < NUM_FUNCT. wr_en=1, rd from [15:11], alu_imm=0.
  - I-type: 1 ≤ opcode ≤ MAX_IMM_OP. wr_en=1, rd from [20:16], alu_funct=0.
  - HALT: opcode == HALT_OP. No bundle issued (out_valid not set by it). FSM RUN→HALTED.
  - Illegal: anything else, including R-type with funct ≥ NUM_FUNCT. Bundle issued with illegal=1, wr_en=0, alu fields 0, reg addrs raw. err set to 1.
- rd_addr == 0: wr_en forced to 0 (r0 not writable).
- FSM states:
  - RUN: normal operation.
  - HALTED: in_ready=0, halted=1. A pending output bundle still drains. resume pulse → RUN on the next edge.
  - resume while in RUN is ignored.
- err clears only on rst.
- Reset mid-transfer discards the pending bundle immediately (asynchronous).

Optional Feature:
Macro DEC_ILLEGAL_CNT_EN.
- Defined: adds output illegal_cnt [15:0], reset 0. Increments by 1 on each accepted illegal instruction and saturates at 16'hFFFF; HALT does not count.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- R-type: in_instr=32'h00221800, out_ready=1 → next cycle out_valid=1, opcode=0, funct=0, rs=1, rt=2, rd=3, wr_en=1, illegal=0.
- I-type: 32'h048500FF → opcode=1, imm=16'h00FF, rs=4, rd=5, funct=0, wr_en=1.
- Backpressure: issue 3 back-to-back instrs with out_ready=0 for 4 cycles → in_ready=0 after the first transfer, the first bundle is held unchanged, then all 3 emerge in order.
- Illegal: 32'h00000009 → out_valid=1, illegal=1, wr_en=0, err=1 sticky. With DEC_ILLEGAL_CNT_EN, illegal_cnt=1.
- HALT: 32'hFC000000 → no bundle, halted=1, in_ready=0 for 5 cycles; resume pulse → next instr accepted.
- Async reset asserted while out_valid=1 → out_valid=0, err=0 without waiting for a clock edge.
